core_lockstep_checker: RTL and testbench

- Runs the golden (single-cycle) core and the segmented (pipelined) core in lockstep and checks their retirement streams against each other.
- Golden retirements are buffered in a DEPTH-entry FIFO because the golden core runs ahead of the pipelined core.
- Each segmented retirement pops one entry and compares PC, destination register and write data.
- On divergence it reports the fault and, optionally, freezes both cores.

---
 rtl/core_lockstep_checker.sv | 274 +++++++++++++++++++++++++++
 tb/tb_core_lockstep_checker.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_lockstep_checker.sv
// Lockstep retirement checker: buffers golden-core retirements and compares them against the
// segmented core. Optional LOCKSTEP_TRACE_EN adds expected/actual capture of the first compare error.
module core_lockstep_checker #(
  parameter int unsigned Xlen        = 32,
  parameter int unsigned Depth       = 8,
  parameter int unsigned Timeout     = 64,
  parameter bit          StopOnError = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   g_valid_i,
  input  logic [Xlen-1:0]        g_pc_i,
  input  logic                   g_we_i,
  input  logic [4:0]             g_rd_i,
  input  logic [Xlen-1:0]        g_wdata_i,
  input  logic                   s_valid_i,
  input  logic [Xlen-1:0]        s_pc_i,
  input  logic                   s_we_i,
  input  logic [4:0]             s_rd_i,
  input  logic [Xlen-1:0]        s_wdata_i,
  output logic                   golden_hold_o,
  output logic                   seg_hold_o,
  output logic                   mismatch_o,
  output logic                   error_o,
  output logic [2:0]             err_code_o,
  output logic [Xlen-1:0]        err_pc_o,
  output logic [31:0]            retired_ok_o,
  output logic [$clog2(Depth):0] fifo_count_o
`ifdef LOCKSTEP_TRACE_EN
  ,
  output logic [4:0]             err_exp_rd_o,
  output logic [Xlen-1:0]        err_exp_wdata_o,
  output logic [4:0]             err_act_rd_o,
  output logic [Xlen-1:0]        err_act_wdata_o,
  output logic                   err_exp_we_o,
  output logic                   err_act_we_o
`endif
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned WdW  = (Timeout > 1) ? $clog2(Timeout) : 1;
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(Depth);

  localparam logic [2:0] ErrNone  = 3'd0;
  localparam logic [2:0] ErrPc    = 3'd1;
  localparam logic [2:0] ErrWeRd  = 3'd2;
  localparam logic [2:0] ErrData  = 3'd3;
  localparam logic [2:0] ErrUnder = 3'd4;
  localparam logic [2:0] ErrOver  = 3'd5;
  localparam logic [2:0] ErrTime  = 3'd6;

  typedef struct packed {
    logic [Xlen-1:0] pc;
    logic            we;
    logic [4:0]      rd;
    logic [Xlen-1:0] wdata;
  } entry_t;

  typedef enum logic [0:0] {StRun, StFault} state_e;

  // A write to x0 is architecturally a no-write, so both sides are normalised before comparing.
  function automatic logic [2:0] cmp_code(entry_t e, entry_t a);
    logic ew, aw;
    ew = e.we & (e.rd != 5'd0);
    aw = a.we & (a.rd != 5'd0);
    if (e.pc != a.pc) begin
      return ErrPc;
    end
    if ((ew != aw) || (ew && (e.rd != a.rd))) begin
      return ErrWeRd;
    end
    if (ew && (e.wdata != a.wdata)) begin
      return ErrData;
    end
    return ErrNone;
  endfunction

  state_e          state_q, state_d;
  entry_t          mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            mismatch_q, mismatch_d;
  logic            error_q, error_d;
  logic [2:0]      err_code_q, err_code_d;
  logic [Xlen-1:0] err_pc_q, err_pc_d;
  logic [31:0]     retired_q, retired_d;

  logic            run, empty, full;
  logic            push, pop, bypass, underflow, overflow, timeout;
  logic            cmp_valid, cmp_err, evt;
  logic [2:0]      cmp_c, evt_code;
  logic [Xlen-1:0] evt_pc;
  entry_t          g_entry, s_entry, head, exp_e;

  always_comb begin
    g_entry = '{pc: g_pc_i, we: g_we_i, rd: g_rd_i, wdata: g_wdata_i};
    s_entry = '{pc: s_pc_i, we: s_we_i, rd: s_rd_i, wdata: s_wdata_i};
    head    = mem_q[rd_ptr_q];

    run   = (state_q == StRun);
    empty = (count_q == '0);
    full  = (count_q == FullCnt);

    // With an empty FIFO, a same-cycle golden retirement is compared directly.
    bypass    = run & s_valid_i & g_valid_i & empty;
    pop       = run & s_valid_i & ~empty;
    push      = run & g_valid_i & ~full & ~bypass;
    underflow = run & s_valid_i & empty & ~g_valid_i;
    overflow  = run & g_valid_i & full;

    exp_e     = bypass ? g_entry : head;
    cmp_valid = pop | bypass;
    cmp_c     = cmp_valid ? cmp_code(exp_e, s_entry) : ErrNone;
    cmp_err   = (cmp_c != ErrNone);

    evt_code = ErrNone;
    evt_pc   = '0;
    if (cmp_err) begin
      evt_code = cmp_c;
      evt_pc   = s_pc_i;
    end else if (underflow) begin
      evt_code = ErrUnder;
      evt_pc   = s_pc_i;
    end else if (overflow) begin
      evt_code = ErrOver;
      evt_pc   = g_pc_i;
    end else if (timeout) begin
      evt_code = ErrTime;
      evt_pc   = head.pc;
    end
    evt = (evt_code != ErrNone);
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    retired_d  = retired_q;
    mismatch_d = evt;
    error_d    = error_q | evt;
    err_code_d = err_code_q;
    err_pc_d   = err_pc_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase

    if (cmp_valid && !cmp_err && (retired_q != '1)) begin
      retired_d = retired_q + 32'd1;
    end

    if (evt && !error_q) begin
      err_code_d = evt_code;
      err_pc_d   = evt_pc;
    end
    if (evt && StopOnError) begin
      state_d = StFault;
    end
  end

  if (Timeout != 0) begin : g_watchdog
    logic [WdW-1:0] wd_q, wd_d;
    localparam logic [WdW-1:0] WdLast = WdW'(Timeout - 1);

    always_comb begin
      wd_d    = wd_q;
      timeout = 1'b0;
      if (run) begin
        if (empty || pop) begin
          wd_d = '0;
        end else if (wd_q == WdLast) begin
          timeout = 1'b1;
          wd_d    = '0;
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        wd_q <= '0;
      end else begin
        wd_q <= wd_d;
      end
    end
  end else begin : g_no_watchdog
    assign timeout = 1'b0;
  end

  // Storage is not reset; occupancy is tracked entirely by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= g_entry;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StRun;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      retired_q  <= '0;
      mismatch_q <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= ErrNone;
      err_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      retired_q  <= retired_d;
      mismatch_q <= mismatch_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
      err_pc_q   <= err_pc_d;
    end
  end

`ifdef LOCKSTEP_TRACE_EN
  logic [4:0]      exp_rd_q, act_rd_q;
  logic [Xlen-1:0] exp_wdata_q, act_wdata_q;
  logic            exp_we_q, act_we_q;
  logic            trace_cap;

  assign trace_cap = cmp_err & ~error_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      exp_rd_q    <= '0;
      act_rd_q    <= '0;
      exp_wdata_q <= '0;
      act_wdata_q <= '0;
      exp_we_q    <= 1'b0;
      act_we_q    <= 1'b0;
    end else if (trace_cap) begin
      exp_rd_q    <= exp_e.rd;
      act_rd_q    <= s_entry.rd;
      exp_wdata_q <= exp_e.wdata;
      act_wdata_q <= s_entry.wdata;
      exp_we_q    <= exp_e.we & (exp_e.rd != 5'd0);
      act_we_q    <= s_entry.we & (s_entry.rd != 5'd0);
    end
  end

  assign err_exp_rd_o    = exp_rd_q;
  assign err_act_rd_o    = act_rd_q;
  assign err_exp_wdata_o = exp_wdata_q;
  assign err_act_wdata_o = act_wdata_q;
  assign err_exp_we_o    = exp_we_q;
  assign err_act_we_o    = act_we_q;
`endif

  assign golden_hold_o = full | (state_q == StFault);
  assign seg_hold_o    = (state_q == StFault);
  assign mismatch_o    = mismatch_q;
  assign error_o       = error_q;
  assign err_code_o    = err_code_q;
  assign err_pc_o      = err_pc_q;
  assign retired_ok_o  = retired_q;
  assign fifo_count_o  = count_q;

endmodule

// File: tb/tb_core_lockstep_checker.sv
// Randomized + directed bench: a stop-on-error and a keep-going checker share stimulus and are
// compared each cycle against queue-based reference models.
module tb_core_lockstep_checker;

  localparam int unsigned Xlen    = 32;
  localparam int unsigned Depth   = 8;
  localparam int unsigned Timeout = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        g_valid, g_we, s_valid, s_we;
  logic [31:0] g_pc, g_wdata, s_pc, s_wdata;
  logic [4:0]  g_rd, s_rd;

  logic        golden_hold [2];
  logic        seg_hold [2];
  logic        mismatch [2];
  logic        error [2];
  logic [2:0]  err_code [2];
  logic [31:0] err_pc [2];
  logic [31:0] retired [2];
  logic [3:0]  fifo_count [2];
`ifdef LOCKSTEP_TRACE_EN
  logic [4:0]  t_exp_rd [2];
  logic [4:0]  t_act_rd [2];
  logic [31:0] t_exp_wd [2];
  logic [31:0] t_act_wd [2];
  logic        t_exp_we [2];
  logic        t_act_we [2];
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, index 0 = stop-on-error, 1 = keep-going.
  ent_t        mq [2][$];
  bit          m_fault [2];
  int          m_idle [2];
  bit          m_mis [2];
  bit          m_err [2];
  int          m_code [2];
  logic [31:0] m_pc [2];
  logic [31:0] m_ok [2];
  logic [4:0]  m_xrd [2];
  logic [4:0]  m_ard [2];
  logic [31:0] m_xwd [2];
  logic [31:0] m_awd [2];
  bit          m_xwe [2];
  bit          m_awe [2];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    core_lockstep_checker #(
      .Xlen       (Xlen),
      .Depth      (Depth),
      .Timeout    (Timeout),
      .StopOnError(k == 0)
    ) u_dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .g_valid_i      (g_valid),
      .g_pc_i         (g_pc),
      .g_we_i         (g_we),
      .g_rd_i         (g_rd),
      .g_wdata_i      (g_wdata),
      .s_valid_i      (s_valid),
      .s_pc_i         (s_pc),
      .s_we_i         (s_we),
      .s_rd_i         (s_rd),
      .s_wdata_i      (s_wdata),
      .golden_hold_o  (golden_hold[k]),
      .seg_hold_o     (seg_hold[k]),
      .mismatch_o     (mismatch[k]),
      .error_o        (error[k]),
      .err_code_o     (err_code[k]),
      .err_pc_o       (err_pc[k]),
      .retired_ok_o   (retired[k]),
      .fifo_count_o   (fifo_count[k])
`ifdef LOCKSTEP_TRACE_EN
      ,
      .err_exp_rd_o   (t_exp_rd[k]),
      .err_exp_wdata_o(t_exp_wd[k]),
      .err_act_rd_o   (t_act_rd[k]),
      .err_act_wdata_o(t_act_wd[k]),
      .err_exp_we_o   (t_exp_we[k]),
      .err_act_we_o   (t_act_we[k])
`endif
    );
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int model_cmp(ent_t e, ent_t a);
    bit ew = e.we && (e.rd != 0);
    bit aw = a.we && (a.rd != 0);
    if (e.pc != a.pc) return 1;
    if (ew != aw) return 2;
    if (ew && e.rd != a.rd) return 2;
    if (ew && e.wdata != a.wdata) return 3;
    return 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      m_fault[k] = 0; m_idle[k] = 0; m_mis[k] = 0; m_err[k] = 0; m_code[k] = 0;
      m_pc[k] = '0; m_ok[k] = '0; m_xrd[k] = '0; m_ard[k] = '0; m_xwd[k] = '0; m_awd[k] = '0;
      m_xwe[k] = 0; m_awe[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input bit stop);
    bit   full  = (mq[k].size() == Depth);
    bit   empty = (mq[k].size() == 0);
    bit   have  = 0;
    int   code  = 0;
    int   c;
    logic [31:0] pc = '0;
    ent_t e_exp, e_act, e_g;
    e_act = '{pc: s_pc, we: s_we, rd: s_rd, wdata: s_wdata};
    e_g   = '{pc: g_pc, we: g_we, rd: g_rd, wdata: g_wdata};
    m_mis[k] = 0;
    if (m_fault[k]) return;
    if (s_valid) begin
      if (!empty) begin
        e_exp = mq[k].pop_front();
        have  = 1;
      end else if (g_valid) begin
        e_exp = e_g;
        have  = 1;
      end else begin
        code = 4; pc = s_pc;
      end
    end
    if (have) begin
      c = model_cmp(e_exp, e_act);
      if (c == 0) begin
        if (m_ok[k] != 32'hFFFF_FFFF) m_ok[k]++;
      end else begin
        code = c; pc = s_pc;
      end
    end
    if (g_valid) begin
      if (full) begin
        if (code == 0) begin code = 5; pc = g_pc; end
      end else if (!(s_valid && empty)) begin
        mq[k].push_back(e_g);
      end
    end
    if (empty || have) begin
      m_idle[k] = 0;
    end else begin
      m_idle[k]++;
      if (m_idle[k] == Timeout) begin
        m_idle[k] = 0;
        if (code == 0) begin code = 6; pc = mq[k][0].pc; end
      end
    end
    if (code != 0) begin
      m_mis[k] = 1;
      if (!m_err[k]) begin
        m_code[k] = code;
        m_pc[k]   = pc;
        if (code <= 3) begin
          m_xrd[k] = e_exp.rd; m_ard[k] = e_act.rd;
          m_xwd[k] = e_exp.wdata; m_awd[k] = e_act.wdata;
          m_xwe[k] = e_exp.we && (e_exp.rd != 0); m_awe[k] = e_act.we && (e_act.rd != 0);
        end
      end
      m_err[k] = 1;
      if (stop) m_fault[k] = 1;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("d%0d_mismatch", k), 64'(mismatch[k]), 64'(m_mis[k]));
      check_eq($sformatf("d%0d_error", k), 64'(error[k]), 64'(m_err[k]));
      check_eq($sformatf("d%0d_err_code", k), 64'(err_code[k]), 64'(m_code[k]));
      check_eq($sformatf("d%0d_err_pc", k), 64'(err_pc[k]), 64'(m_pc[k]));
      check_eq($sformatf("d%0d_retired_ok", k), 64'(retired[k]), 64'(m_ok[k]));
      check_eq($sformatf("d%0d_fifo_count", k), 64'(fifo_count[k]), 64'(mq[k].size()));
      check_eq($sformatf("d%0d_golden_hold", k), 64'(golden_hold[k]),
               64'(m_fault[k] || (mq[k].size() == Depth)));
      check_eq($sformatf("d%0d_seg_hold", k), 64'(seg_hold[k]), 64'(m_fault[k]));
`ifdef LOCKSTEP_TRACE_EN
      check_eq($sformatf("d%0d_exp_rd", k), 64'(t_exp_rd[k]), 64'(m_xrd[k]));
      check_eq($sformatf("d%0d_act_rd", k), 64'(t_act_rd[k]), 64'(m_ard[k]));
      check_eq($sformatf("d%0d_exp_wdata", k), 64'(t_exp_wd[k]), 64'(m_xwd[k]));
      check_eq($sformatf("d%0d_act_wdata", k), 64'(t_act_wd[k]), 64'(m_awd[k]));
      check_eq($sformatf("d%0d_exp_we", k), 64'(t_exp_we[k]), 64'(m_xwe[k]));
      check_eq($sformatf("d%0d_act_we", k), 64'(t_act_we[k]), 64'(m_awe[k]));
`endif
    end
  endtask

  task automatic clear_in();
    g_valid = 0; g_pc = '0; g_we = 0; g_rd = '0; g_wdata = '0;
    s_valid = 0; s_pc = '0; s_we = 0; s_rd = '0; s_wdata = '0;
  endtask

  task automatic set_g(input logic [31:0] pc, input logic we, input logic [4:0] rd,
                       input logic [31:0] wd);
    g_valid = 1; g_pc = pc; g_we = we; g_rd = rd; g_wdata = wd;
  endtask

  task automatic set_s(input logic [31:0] pc, input logic we, input logic [4:0] rd,
                       input logic [31:0] wd);
    s_valid = 1; s_pc = pc; s_we = we; s_rd = rd; s_wdata = wd;
  endtask

  task automatic step();
    @(posedge clk);
    model_step(0, 1'b1);
    model_step(1, 1'b0);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    ent_t ge, se;
    ent_t stim [$];
    bit   gv, sv, byp;

    clear_in();
    do_reset();

    // In-order stream: three golden retirements then the same three from the segmented core.
    for (int i = 0; i < 3; i++) begin
      set_g(32'(i * 4), 1'b1, 5'd5, 32'(i + 1));
      step();
    end
    clear_in();
    check_eq("tp1_peak_count", 64'(fifo_count[0]), 64'd3);
    for (int i = 0; i < 3; i++) begin
      set_s(32'(i * 4), 1'b1, 5'd5, 32'(i + 1));
      step();
    end
    clear_in();
    step();
    check_eq("tp1_retired", 64'(retired[0]), 64'd3);
    check_eq("tp1_count0", 64'(fifo_count[0]), 64'd0);
    check_eq("tp1_no_error", 64'(error[0]), 64'd0);

    // Write-data divergence.
    do_reset();
    set_g(32'h4, 1'b1, 5'd5, 32'h22);
    step();
    clear_in();
    set_s(32'h4, 1'b1, 5'd5, 32'h11);
    step();
    clear_in();
    check_eq("tp2_mismatch", 64'(mismatch[0]), 64'd1);
    check_eq("tp2_code", 64'(err_code[0]), 64'd3);
    check_eq("tp2_pc", 64'(err_pc[0]), 64'h4);
    check_eq("tp2_holds", 64'({golden_hold[0], seg_hold[0]}), 64'd3);
`ifdef LOCKSTEP_TRACE_EN
    check_eq("tp2_exp_wdata", 64'(t_exp_wd[0]), 64'h22);
    check_eq("tp2_act_wdata", 64'(t_act_wd[0]), 64'h11);
`endif
    step();
    check_eq("tp2_pulse_end", 64'(mismatch[0]), 64'd0);

    // Fill to capacity, then violate the hold.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_g(32'(i * 4), 1'b1, 5'd1, 32'(i));
      step();
    end
    check_eq("tp3_full_hold", 64'(golden_hold[1]), 64'd1);
    check_eq("tp3_full_count", 64'(fifo_count[1]), 64'd8);
    set_g(32'h20, 1'b1, 5'd1, 32'h8);
    step();
    clear_in();
    check_eq("tp3_overflow", 64'(err_code[0]), 64'd5);
    check_eq("tp3_overflow_pc", 64'(err_pc[0]), 64'h20);

    // x0 write normalisation and bypass.
    do_reset();
    set_g(32'h10, 1'b1, 5'd0, 32'hDEAD);
    step();
    clear_in();
    set_s(32'h10, 1'b0, 5'd0, 32'h0);
    step();
    clear_in();
    check_eq("tp4_retired", 64'(retired[0]), 64'd1);
    check_eq("tp4_no_error", 64'(error[0]), 64'd0);
    set_g(32'h14, 1'b1, 5'd3, 32'h7);
    set_s(32'h14, 1'b1, 5'd3, 32'h7);
    step();
    clear_in();
    check_eq("bypass_retired", 64'(retired[0]), 64'd2);
    check_eq("bypass_count", 64'(fifo_count[0]), 64'd0);

    // Watchdog, then underflow.
    do_reset();
    set_g(32'h40, 1'b1, 5'd2, 32'h1);
    step();
    clear_in();
    repeat (63) step();
    check_eq("tp5_before_timeout", 64'(error[0]), 64'd0);
    step();
    check_eq("tp5_timeout", 64'(err_code[0]), 64'd6);
    check_eq("tp5_timeout_pc", 64'(err_pc[0]), 64'h40);
    do_reset();
    set_s(32'h80, 1'b1, 5'd2, 32'h1);
    step();
    clear_in();
    check_eq("tp5_underflow", 64'(err_code[0]), 64'd4);

    // Keep-going variant: pc error followed by three good retirements.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_g(32'(i * 4), 1'b1, 5'd6, 32'(i + 9));
      step();
    end
    clear_in();
    set_s(32'h100, 1'b1, 5'd6, 32'd9);
    step();
    for (int i = 1; i < 4; i++) begin
      set_s(32'(i * 4), 1'b1, 5'd6, 32'(i + 9));
      step();
    end
    clear_in();
    check_eq("tp6_error", 64'(error[1]), 64'd1);
    check_eq("tp6_code", 64'(err_code[1]), 64'd1);
    check_eq("tp6_retired", 64'(retired[1]), 64'd3);
    check_eq("tp6_holds", 64'({golden_hold[1], seg_hold[1]}), 64'd0);

    // Asynchronous reset in the middle of traffic.
    set_g(32'h200, 1'b1, 5'd1, 32'h1);
    step();
    set_g(32'h204, 1'b1, 5'd1, 32'h2);
    #2;
    rst = 1;
    #1;
    check_eq("areset_count", 64'(fifo_count[1]), 64'd0);
    check_eq("areset_error", 64'(error[1]), 64'd0);
    check_eq("areset_code", 64'(err_code[1]), 64'd0);
    check_eq("areset_retired", 64'(retired[1]), 64'd0);
    model_reset();
    do_reset();

    // Randomized episodes.
    for (int ep = 0; ep < 20; ep++) begin
      do_reset();
      stim.delete();
      repeat (150) begin
        ge.pc    = 32'($urandom_range(0, 63)) << 2;
        ge.we    = 1'($urandom_range(0, 1));
        ge.rd    = 5'($urandom_range(0, 3));
        ge.wdata = 32'($urandom_range(0, 3));
        gv  = ($urandom_range(0, 2) != 0) &&
              ((mq[1].size() < Depth) || ($urandom_range(0, 39) == 0));
        sv  = 0;
        byp = 0;
        se  = ge;
        if (stim.size() > 0 && $urandom_range(0, 1) == 1) begin
          se = stim.pop_front();
          sv = 1;
        end else if (stim.size() == 0 && gv && $urandom_range(0, 2) == 0) begin
          sv  = 1;
          byp = 1;
        end else if ($urandom_range(0, 59) == 0) begin
          sv = 1;
        end
        if (sv) begin
          if (se.rd == 0) se.we = 1'($urandom_range(0, 1));
          if (!se.we || se.rd == 0) se.wdata = 32'($urandom());
          if ($urandom_range(0, 39) == 0) begin
            case ($urandom_range(0, 2))
              0:       se.pc = se.pc ^ 32'h4;
              1:       se.rd = se.rd ^ 5'd1;
              default: se.wdata = se.wdata ^ 32'h1;
            endcase
          end
        end
        if (gv && !byp) stim.push_back(ge);
        clear_in();
        if (gv) set_g(ge.pc, ge.we, ge.rd, ge.wdata);
        if (sv) set_s(se.pc, se.we, se.rd, se.wdata);
        step();
      end
    end

    clear_in();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
